control_fsm: RTL

- Multicycle control unit directly upstream of the processor datapath.
- Decodes the instruction opcode latched by the datapath IR and sequences fetch, decode, execute, memory and writeback states.
- Drives every datapath mux/write-enable, and exports current/next state (CS/NS, 5 bits) for bench observation.
- Stalls on a memory-ready handshake; counts retired instructions.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_decode.sv | 84 ++++++++
 rtl/control_fsm.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, mux codes, control vector.
// The CTRL_TRAP_EN build makes the TRAP state reachable on illegal opcodes.
package ctrl_pkg;

  localparam int STATE_BITS = 5;
  localparam int OP_BITS    = 4;

  localparam logic [STATE_BITS-1:0] S_FETCH   = 5'd0;
  localparam logic [STATE_BITS-1:0] S_DECODE  = 5'd1;
  localparam logic [STATE_BITS-1:0] S_MEMADDR = 5'd2;
  localparam logic [STATE_BITS-1:0] S_MEMRD   = 5'd3;
  localparam logic [STATE_BITS-1:0] S_MEMWB   = 5'd4;
  localparam logic [STATE_BITS-1:0] S_MEMWR   = 5'd5;
  localparam logic [STATE_BITS-1:0] S_REXEC   = 5'd6;
  localparam logic [STATE_BITS-1:0] S_RWB     = 5'd7;
  localparam logic [STATE_BITS-1:0] S_IEXEC   = 5'd8;
  localparam logic [STATE_BITS-1:0] S_IWB     = 5'd9;
  localparam logic [STATE_BITS-1:0] S_BRANCH  = 5'd10;
  localparam logic [STATE_BITS-1:0] S_JUMP    = 5'd11;
  localparam logic [STATE_BITS-1:0] S_JAL     = 5'd12;
  localparam logic [STATE_BITS-1:0] S_TRAP    = 5'd31;

  localparam logic [OP_BITS-1:0] OP_R    = 4'd0;
  localparam logic [OP_BITS-1:0] OP_ADDI = 4'd1;
  localparam logic [OP_BITS-1:0] OP_LW   = 4'd2;
  localparam logic [OP_BITS-1:0] OP_SW   = 4'd3;
  localparam logic [OP_BITS-1:0] OP_BEQ  = 4'd4;
  localparam logic [OP_BITS-1:0] OP_BNE  = 4'd5;
  localparam logic [OP_BITS-1:0] OP_J    = 4'd6;
  localparam logic [OP_BITS-1:0] OP_JAL  = 4'd7;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_ONE   = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_PASSB = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       branch_ne;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Moore decode of the current state into the datapath control vector.
// Memory-side writes in FETCH/MEMWR are qualified by mem_ready so a stalled access writes nothing.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int STATE_W = STATE_BITS,
  parameter int OP_W    = OP_BITS
) (
  input  logic [STATE_W-1:0] cs,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (cs)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
      end
      // branch target precomputed while the register file is read
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = mem_ready;
        ctrl.iord      = 1'b1;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_IWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM: state register, next-state logic and retired-instruction counter.
// Define CTRL_TRAP_EN to trap (sticky, until reset) on illegal opcodes instead of treating them as NOPs.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int STATE_W = STATE_BITS,
  parameter int OP_W    = OP_BITS,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               ResetL,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic [STATE_W-1:0] CS,
  output logic [STATE_W-1:0] NS,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               BranchNE,
  output logic [CNT_W-1:0]   InstrCount,
  output logic               Trap
);

`ifdef CTRL_TRAP_EN
  localparam logic [STATE_W-1:0] ILLEGAL_NS = S_TRAP;
`else
  localparam logic [STATE_W-1:0] ILLEGAL_NS = S_FETCH;
`endif

  logic [STATE_W-1:0] cs_q, ns;
  logic [CNT_W-1:0]   cnt_q;
  ctrl_t              ctrl;

  // Zero is consumed by the datapath branch logic together with BranchNE
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL) cs_q <= S_FETCH;
    else         cs_q <= ns;
  end

  always_comb begin
    ns = S_FETCH;
    case (cs_q)
      S_FETCH:  ns = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_R:          ns = S_REXEC;
          OP_ADDI:       ns = S_IEXEC;
          OP_LW, OP_SW:  ns = S_MEMADDR;
          OP_BEQ, OP_BNE: ns = S_BRANCH;
          OP_J:          ns = S_JUMP;
          OP_JAL:        ns = S_JAL;
          default:       ns = ILLEGAL_NS;
        endcase
      end
      S_MEMADDR: begin
        if (Opcode == OP_LW)      ns = S_MEMRD;
        else if (Opcode == OP_SW) ns = S_MEMWR;
        else                      ns = S_FETCH;
      end
      S_MEMRD:  ns = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  ns = MemReady ? S_FETCH : S_MEMWR;
      S_REXEC:  ns = S_RWB;
      S_IEXEC:  ns = S_IWB;
      S_RWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP, S_JAL: ns = S_FETCH;
`ifdef CTRL_TRAP_EN
      S_TRAP:   ns = S_TRAP;
`endif
      default:  ns = S_FETCH;
    endcase
  end

  // an instruction retires on the edge that returns the FSM to FETCH
  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL)                              cnt_q <= '0;
    else if (ns == S_FETCH && cs_q != S_FETCH) cnt_q <= cnt_q + CNT_W'(1);
  end

  ctrl_decode #(
    .STATE_W (STATE_W),
    .OP_W    (OP_W)
  ) u_decode (
    .cs        (cs_q),
    .opcode    (Opcode),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign CS          = cs_q;
  assign NS          = ns;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.memto_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign BranchNE    = ctrl.branch_ne;
  assign InstrCount  = cnt_q;

`ifdef CTRL_TRAP_EN
  // TRAP only exits through reset, so the state decode is already sticky
  assign Trap = (cs_q == S_TRAP);
`else
  assign Trap = 1'b0;
`endif

endmodule
